// File: rtl/dmem_write_snoop.sv
// rtl/dmem_write_snoop.sv - snoops dmem stores into a window and queues them for a display consumer
//
// Ports:
//   clock, reset         : system clock; asynchronous active-low reset
//   dmem_addr/data/wren  : tapped processor dmem write interface (never driven)
//   out_valid/out_ready  : show-ahead FIFO head handshake
//   out_offset/out_data  : head entry (window offset, store data)
//   fifo_count           : occupied entries
//   overflow_flag/count  : sticky drop indicator and saturating drop counter
//   clear_overflow       : synchronous clear of the overflow state
module dmem_write_snoop #(
   parameter logic [11:0] ADDR_BASE = 12'hC00,
   parameter int          ADDR_SPAN = 256,
   parameter int          DEPTH     = 8,
   parameter int          OFS_W     = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [11:0]              dmem_addr,
   input  logic [31:0]              dmem_data,
   input  logic                     dmem_wren,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OFS_W-1:0]         out_offset,
   output logic [31:0]              out_data,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow_flag,
   output logic [7:0]               overflow_count,
   input  logic                     clear_overflow
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int SPAN_W = $clog2(ADDR_SPAN);
   localparam int ENT_W  = OFS_W + 32;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   // Pointers carry one extra MSB so a full FIFO differs from an empty one.
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic [ENT_W-1:0] mem [DEPTH];
   logic [ENT_W-1:0] head;

   logic hit;
   logic full;
   logic pop;
   logic push;
   logic drop;

   assign hit  = dmem_wren & (dmem_addr[11:SPAN_W] == ADDR_BASE[11:SPAN_W]);
   assign fifo_count = wr_ptr - rd_ptr;
   assign full = (fifo_count == FULL_CNT);
   assign out_valid = (fifo_count != '0);
   assign pop  = out_valid & out_ready;
   // A pop in the same edge frees the slot a full-FIFO store needs.
   assign push = hit & (~full | pop);
   assign drop = hit & full & ~pop;

   assign head       = mem[rd_ptr[PTR_W-1:0]];
   assign out_offset = out_valid ? head[ENT_W-1:32] : '0;
   assign out_data   = out_valid ? head[31:0]       : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= {dmem_addr[OFS_W-1:0], dmem_data};
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // A drop on the same edge as a clear wins, restarting the count at one.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         overflow_flag  <= 1'b0;
         overflow_count <= '0;
      end else if (drop) begin
         overflow_flag <= 1'b1;
         if (clear_overflow) begin
            overflow_count <= 8'd1;
         end else if (overflow_count != 8'hFF) begin
            overflow_count <= overflow_count + 8'd1;
         end
      end else if (clear_overflow) begin
         overflow_flag  <= 1'b0;
         overflow_count <= '0;
      end
   end

endmodule

// File: tb/tb_dmem_write_snoop.sv
// tb/tb_dmem_write_snoop.sv - self-checking bench for dmem_write_snoop
module tb_dmem_write_snoop;

   localparam int BASE  = 'hC00;
   localparam int SPAN  = 256;
   localparam int DEPTH = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] dmem_addr = '0;
   logic [31:0] dmem_data = '0;
   logic        dmem_wren = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_offset;
   logic [31:0] out_data;
   logic [3:0]  fifo_count;
   logic        overflow_flag;
   logic [7:0]  overflow_count;
   logic        clear_overflow = 1'b0;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: queue of {offset, data} plus overflow state.
   logic [39:0] mq[$];
   bit          m_flag = 0;
   int          m_cnt  = 0;

   dmem_write_snoop dut (
      .clock          (clock),
      .reset          (reset),
      .dmem_addr      (dmem_addr),
      .dmem_data      (dmem_data),
      .dmem_wren      (dmem_wren),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_offset     (out_offset),
      .out_data       (out_data),
      .fifo_count     (fifo_count),
      .overflow_flag  (overflow_flag),
      .overflow_count (overflow_count),
      .clear_overflow (clear_overflow)
   );

   always #5 clock = ~clock;

   // Advance the model by one clock edge using the inputs now applied, then step the DUT.
   task automatic tick();
      int  a;
      bit  hit, drop;
      a    = int'(dmem_addr);
      hit  = dmem_wren && (a >= BASE) && (a < BASE + SPAN);
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      drop = hit && (mq.size() >= DEPTH);
      if (hit && !drop) mq.push_back({8'(a - BASE), dmem_data});
      if (drop) begin
         m_flag = 1;
         m_cnt  = clear_overflow ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      end else if (clear_overflow) begin
         m_flag = 0;
         m_cnt  = 0;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic store(input int ofs, input logic [31:0] d);
      dmem_addr = 12'(BASE + ofs);
      dmem_data = d;
      dmem_wren = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      dmem_wren = 1'b0;
      out_ready = 1'b0;
      clear_overflow = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      mq.delete();
      m_flag = 0;
      m_cnt  = 0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         dmem_addr = 12'($urandom_range(BASE, BASE + SPAN - 1));
         dmem_data = $urandom;
         dmem_wren = 1'($urandom);
         out_ready = 1'($urandom);
         @(posedge clock);
         #1;
         n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", out_valid); else n_pass++;
         n_total++; if (fifo_count !== 4'd0) $display("FAIL reset_count got %0d exp 0", fifo_count); else n_pass++;
         n_total++; if (overflow_count !== 8'd0) $display("FAIL reset_ovf got %0d exp 0", overflow_count); else n_pass++;
         n_total++; if (out_data !== 32'd0) $display("FAIL reset_data got %h exp 0", out_data); else n_pass++;
      end
      reset = 1'b1;
      mq.delete();
      out_ready = 1'b0;
      dmem_addr = 12'h100;
      dmem_data = 32'h1234_5678;
      dmem_wren = 1'b1;
      tick();
      dmem_wren = 1'b0;
      n_total++; if (out_valid !== 1'b0) $display("FAIL miss_valid got %0b exp 0", out_valid); else n_pass++;
      n_total++; if (fifo_count !== 4'd0) $display("FAIL miss_count got %0d exp 0", fifo_count); else n_pass++;
   endtask

   task automatic test_single_capture();
      out_ready = 1'b0;
      store('h05, 32'hDEADBEEF);
      tick();
      dmem_wren = 1'b0;
      for (int c = 0; c < 6; c++) begin
         n_total++; if (out_valid !== 1'b1) $display("FAIL single_valid cyc%0d got %0b exp 1", c, out_valid); else n_pass++;
         n_total++; if (out_offset !== 8'h05) $display("FAIL single_offset cyc%0d got %h exp 05", c, out_offset); else n_pass++;
         n_total++; if (out_data !== 32'hDEADBEEF) $display("FAIL single_data cyc%0d got %h exp deadbeef", c, out_data); else n_pass++;
         n_total++; if (fifo_count !== 4'd1) $display("FAIL single_count cyc%0d got %0d exp 1", c, fifo_count); else n_pass++;
         if (c < 5) tick();
      end
      out_ready = 1'b1;
      tick();
      n_total++; if (out_valid !== 1'b0) $display("FAIL single_pop got %0b exp 0", out_valid); else n_pass++;
   endtask

   task automatic test_order_wrap();
      logic [39:0] got[$];
      out_ready = 1'b1;
      for (int i = 0; i <= 20; i++) begin
         if (i < 20) store(i, 32'(i));
         else dmem_wren = 1'b0;
         if (out_valid) got.push_back({out_offset, out_data});
         tick();
      end
      n_total++; if (got.size() != 20) $display("FAIL order_len got %0d exp 20", got.size()); else n_pass++;
      for (int k = 0; k < got.size() && k < 20; k++) begin
         n_total++; if (got[k] !== {8'(k), 32'(k)}) $display("FAIL order_entry%0d got %h exp %h", k, got[k], {8'(k), 32'(k)}); else n_pass++;
      end
      n_total++; if (out_valid !== 1'b0) $display("FAIL order_empty got %0b exp 0", out_valid); else n_pass++;
      n_total++; if (overflow_count !== 8'd0) $display("FAIL order_ovf got %0d exp 0", overflow_count); else n_pass++;
   endtask

   task automatic test_overflow();
      int first_ofs;
      do_reset();
      out_ready = 1'b0;
      first_ofs = $urandom_range(0, SPAN - 1);
      for (int i = 0; i < 10; i++) begin
         store((i == 0) ? first_ofs : $urandom_range(0, SPAN - 1), $urandom);
         tick();
      end
      dmem_wren = 1'b0;
      n_total++; if (fifo_count !== 4'd8) $display("FAIL ovf_count_fifo got %0d exp 8", fifo_count); else n_pass++;
      n_total++; if (overflow_flag !== 1'b1) $display("FAIL ovf_flag got %0b exp 1", overflow_flag); else n_pass++;
      n_total++; if (overflow_count !== 8'd2) $display("FAIL ovf_cnt got %0d exp 2", overflow_count); else n_pass++;
      n_total++; if (out_offset !== 8'(first_ofs)) $display("FAIL ovf_head got %h exp %h", out_offset, 8'(first_ofs)); else n_pass++;
      for (int i = 0; i < 300; i++) begin
         store($urandom_range(0, SPAN - 1), $urandom);
         tick();
      end
      dmem_wren = 1'b0;
      n_total++; if (overflow_count !== 8'd255) $display("FAIL ovf_sat got %0d exp 255", overflow_count); else n_pass++;
      n_total++; if (fifo_count !== 4'd8) $display("FAIL ovf_sat_fifo got %0d exp 8", fifo_count); else n_pass++;
      n_total++; if (out_offset !== 8'(first_ofs)) $display("FAIL ovf_sat_head got %h exp %h", out_offset, 8'(first_ofs)); else n_pass++;
   endtask

   task automatic test_full_push_pop();
      out_ready = 1'b1;
      store('h77, 32'hA5A5_0000);
      tick();
      dmem_wren = 1'b0;
      n_total++; if (fifo_count !== 4'd8) $display("FAIL fpp_count got %0d exp 8", fifo_count); else n_pass++;
      n_total++; if (overflow_count !== 8'd255) $display("FAIL fpp_ovf got %0d exp 255", overflow_count); else n_pass++;
      for (int k = 0; k < 8; k++) begin
         n_total++; if ({out_offset, out_data} !== mq[0]) $display("FAIL fpp_head%0d got %h exp %h", k, {out_offset, out_data}, mq[0]); else n_pass++;
         if (k == 7) begin
            n_total++; if ({out_offset, out_data} !== {8'h77, 32'hA5A5_0000}) $display("FAIL fpp_last got %h exp 77a5a50000", {out_offset, out_data}); else n_pass++;
         end
         tick();
      end
      n_total++; if (out_valid !== 1'b0) $display("FAIL fpp_drained got %0b exp 0", out_valid); else n_pass++;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         store(i, $urandom);
         tick();
      end
      store('h40, 32'h0BAD_0BAD);
      clear_overflow = 1'b1;
      tick();
      dmem_wren = 1'b0;
      n_total++; if (overflow_count !== 8'd1) $display("FAIL clr_drop_cnt got %0d exp 1", overflow_count); else n_pass++;
      n_total++; if (overflow_flag !== 1'b1) $display("FAIL clr_drop_flag got %0b exp 1", overflow_flag); else n_pass++;
      n_total++; if (fifo_count !== 4'd8) $display("FAIL clr_drop_fifo got %0d exp 8", fifo_count); else n_pass++;
      tick();
      clear_overflow = 1'b0;
      n_total++; if (overflow_count !== 8'd0) $display("FAIL clr_cnt got %0d exp 0", overflow_count); else n_pass++;
      n_total++; if (overflow_flag !== 1'b0) $display("FAIL clr_flag got %0b exp 0", overflow_flag); else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         store(i + 3, $urandom);
         tick();
      end
      dmem_wren = 1'b0;
      n_total++; if (fifo_count !== 4'd5) $display("FAIL mid_pre_count got %0d exp 5", fifo_count); else n_pass++;
      reset = 1'b0;
      #1;
      n_total++; if (out_valid !== 1'b0) $display("FAIL mid_async_valid got %0b exp 0", out_valid); else n_pass++;
      @(posedge clock);
      #1;
      reset = 1'b1;
      mq.delete();
      m_flag = 0;
      m_cnt  = 0;
      n_total++; if (fifo_count !== 4'd0) $display("FAIL mid_count got %0d exp 0", fifo_count); else n_pass++;
      store('h10, 32'h1234_5678);
      tick();
      dmem_wren = 1'b0;
      n_total++; if ({out_valid, out_offset, out_data} !== {1'b1, 8'h10, 32'h1234_5678}) $display("FAIL mid_capture got %b/%h/%h exp 1/10/12345678", out_valid, out_offset, out_data); else n_pass++;
      n_total++; if (fifo_count !== 4'd1) $display("FAIL mid_capture_count got %0d exp 1", fifo_count); else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) != 0) dmem_addr = 12'($urandom_range(BASE - 8, BASE + SPAN + 7));
         else dmem_addr = 12'($urandom);
         dmem_data = $urandom;
         dmem_wren = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 3) == 0);
         clear_overflow = ($urandom_range(0, 31) == 0);
         tick();
         n_total++; if (fifo_count !== 4'(mq.size())) $display("FAIL rnd_count c%0d got %0d exp %0d", c, fifo_count, mq.size()); else n_pass++;
         n_total++; if (out_valid !== (mq.size() != 0)) $display("FAIL rnd_valid c%0d got %0b exp %0b", c, out_valid, mq.size() != 0); else n_pass++;
         if (mq.size() != 0) begin
            n_total++; if ({out_offset, out_data} !== mq[0]) $display("FAIL rnd_head c%0d got %h exp %h", c, {out_offset, out_data}, mq[0]); else n_pass++;
         end
         n_total++; if (overflow_flag !== m_flag) $display("FAIL rnd_flag c%0d got %0b exp %0b", c, overflow_flag, m_flag); else n_pass++;
         n_total++; if (overflow_count !== 8'(m_cnt)) $display("FAIL rnd_ovf c%0d got %0d exp %0d", c, overflow_count, m_cnt); else n_pass++;
      end
      dmem_wren = 1'b0;
      clear_overflow = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_capture();
      test_order_wrap();
      test_overflow();
      test_full_push_pop();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dmem_write_snoop.md
Name: dmem_write_snoop

Overview:
- Sits directly downstream of the processor/memory wrapper; taps its dmem address, write-data and write-enable outputs.
- Captures every processor store that lands in a memory-mapped window, such as the Tetris board/display region.
- Buffers each captured store in a small FIFO and hands it to the display-side consumer over a valid/ready handshake.
- The CPU never stalls: stores that arrive when the FIFO is full are dropped and counted.

Parameters:
- ADDR_BASE, 12'hC00, first dmem word address of the snooped window.
- ADDR_SPAN, 256, window size in words; power of 2; ADDR_BASE must be a multiple of ADDR_SPAN.
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- OFS_W, 8, width of the window offset; equals log2(ADDR_SPAN).

Ports:
- clock, in, 1, single system clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-low: asserted when 0; deassertion is synchronous to clock upstream.
- dmem_addr, in, 12, dmem word address from the processor wrapper.
- dmem_data, in, 32, dmem write data.
- dmem_wren, in, 1, dmem write enable.
- out_valid, out, 1, FIFO head is valid.
- out_ready, in, 1, consumer accepts the head this cycle.
- out_offset, out, OFS_W, dmem_addr minus ADDR_BASE of the head entry.
- out_data, out, 32, write data of the head entry.
- fifo_count, out, log2(DEPTH)+1, number of occupied entries.
- overflow_flag, out, 1, sticky; set when any store is dropped.
- overflow_count, out, 8, number of dropped stores; saturates at 255.
- clear_overflow, in, 1, synchronous clear of overflow_flag and overflow_count.

Behaviour:
- Reset (reset=0, asynchronous):
  - Read and write pointers, fifo_count, overflow_flag and overflow_count go to 0.
  - out_valid=0; out_offset and out_data read 0.
  - Reset asserted mid-operation flushes all entries; nothing is replayed after release.
- Hit detection (combinational): hit = dmem_wren & (dmem_addr[11:OFS_W] == ADDR_BASE[11:OFS_W]).
- Push: on a rising edge with hit=1, store {dmem_addr[OFS_W-1:0], dmem_data} at the write pointer and advance the write pointer modulo DEPTH.
- Reads: reads (dmem_wren=0) and out-of-window writes are ignored.
- Show-ahead FIFO:
  - out_valid = (fifo_count != 0), driven from registered state.
  - out_offset and out_data present the entry at the read pointer.
  - Latency: a store sampled at edge N gives out_valid=1 in the cycle after edge N (1-cycle latency into an empty FIFO).
- Pop: on a rising edge with out_valid & out_ready, advance the read pointer modulo DEPTH.
  - out_ready while out_valid=0 has no effect.
- Hold: while out_valid=1 and out_ready=0, out_offset and out_data stay constant.
- Ordering: strict FIFO order; no coalescing of repeated writes to the same address.
- Simultaneous push and pop:
  - count unchanged.
  - When empty: the push lands, and no pop occurs because out_valid was 0.
  - When full (count==DEPTH): the pop frees a slot and the push is accepted; count stays DEPTH and nothing is dropped.
- Overflow: on a hit with count==DEPTH and no pop in that cycle:
  - The store is dropped and FIFO contents are unchanged.
  - overflow_flag<=1.
  - overflow_count<=min(overflow_count+1, 255).
- clear_overflow=1:
  - With no drop in the same edge: flag<=0 and count<=0.
  - With a drop in the same edge: the event wins; flag<=1 and count<=1.
- Pointer wrap: pointers carry one extra MSB so full and empty are distinguishable; fifo_count = wr_ptr - rd_ptr.
- Reset is the only path that touches FIFO contents. The block never drives dmem and never back-pressures the processor.

Test Plan:
- Reset/idle: hold reset=0 with random dmem activity → out_valid=0, fifo_count=0, overflow_count=0. Release and issue a store to 12'h100 → no capture.
- Single capture: store 32'hDEADBEEF to 12'hC05 at edge N with out_ready=0 → after edge N, out_valid=1, out_offset=8'h05, out_data=32'hDEADBEEF, fifo_count=1. These stay stable for 5 cycles; assert out_ready and the next edge gives out_valid=0.
- Ordering and wrap: 20 back-to-back stores to C00..C13, data = i, with out_ready=1 continuously → 20 outputs in order with offsets 0..0x13, no drops, pointers wrap twice.
- Overflow: out_ready=0, 10 stores to the window → fifo_count=8, overflow_flag=1, overflow_count=2, head offset is the first store. Then 300 more drops → overflow_count=255.
- Full with simultaneous push and pop: with the FIFO full, issue a store and assert out_ready in the same cycle → count stays 8, overflow_count unchanged, the new entry is delivered last. Separately, clear_overflow coinciding with a drop → overflow_count=1.
- Reset mid-stream: with 5 entries queued, pulse reset=0 for 1 cycle → out_valid=0 immediately (asynchronous), fifo_count=0 afterwards, and the next store is captured normally.
